// File: rtl/stream_filter_engine.sv
// stream_filter_engine: raster reader with two line buffers and a 3x3 window, writes pixels back by address.
// Define GAUSS3_EN for the rounded 3x3 Gaussian on interior pixels; otherwise the centre pixel passes through.
module stream_filter_engine #(
  parameter int WIDTH = 256,
  parameter int HEIGHT = 256,
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          finish
);
  localparam logic [AW:0] FIRST = (AW+1)'(WIDTH + 1);
  localparam logic [AW:0] LAST = (AW+1)'(WIDTH * HEIGHT + WIDTH);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state;
  logic [AW:0] icnt, cap_cnt;
  logic [AW-1:0] opix, src_addr;
  logic cap_v, win_v, iss, src_v;
  logic [DW-1:0] pix, src_data;
  logic [WIDTH-1:0][DW-1:0] lb0, lb1;
  logic [2:0][DW-1:0] top;
  // Past the last real address, DRAIN feeds WIDTH+1 zero pixels to flush the window.
  assign iss = (state == READ && in_valid) || (state == DRAIN && icnt <= LAST);
  assign pix = cap_cnt[AW] ? '0 : in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      in_addr <= '0;
      icnt <= '0;
      cap_cnt <= '0;
      cap_v <= 1'b0;
      win_v <= 1'b0;
      opix <= '0;
      out_valid <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      finish <= 1'b0;
    end else begin
      cap_v <= iss;
      win_v <= cap_v && cap_cnt >= FIRST;
      out_valid <= src_v;
      if (iss) icnt <= icnt + 1'b1;
      if (cap_v) cap_cnt <= cap_cnt + 1'b1;
      if (win_v) opix <= opix + 1'b1;
      if (src_v) begin
        out_addr <= src_addr;
        out_data <= src_data;
      end
      case (state)
        IDLE: if (in_valid) state <= READ;
        READ: if (in_valid) begin
          if (in_addr == '1) state <= DRAIN;
          else in_addr <= in_addr + 1'b1;
        end
        DRAIN: if (out_valid && out_addr == '1) begin
          state <= DONE;
          finish <= 1'b1;
        end
        default: ;
      endcase
    end
  // After capturing pixel k: lb0[j]=k-j, lb1[j]=k-WIDTH-j, top[j]=k-2*WIDTH-j; centre is lb1[1].
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lb0 <= '0;
      lb1 <= '0;
      top <= '0;
    end else if (cap_v) begin
      lb0 <= {lb0[WIDTH-2:0], pix};
      lb1 <= {lb1[WIDTH-2:0], lb0[WIDTH-1]};
      top <= {top[1:0], lb1[WIDTH-1]};
    end
`ifdef GAUSS3_EN
  localparam int CB = $clog2(WIDTH);
  localparam int SW = DW + 4;
  logic [SW-1:0] sum;
  logic [CB-1:0] col;
  logic [AW-CB-1:0] row;
  logic border, g_v;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] res, g_data;
  assign col = opix[CB-1:0];
  assign row = opix[AW-1:CB];
  assign border = row == '0 || row == (AW-CB)'(HEIGHT - 1) || col == '0 || col == '1;
  assign sum = (SW'(lb1[1]) << 2)
             + ((SW'(top[1]) + SW'(lb1[0]) + SW'(lb1[2]) + SW'(lb0[1])) << 1)
             + SW'(top[0]) + SW'(top[2]) + SW'(lb0[0]) + SW'(lb0[2]);
  assign res = border ? lb1[1] : DW'((sum + SW'(8)) >> 4);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      g_v <= 1'b0;
      g_addr <= '0;
      g_data <= '0;
    end else begin
      g_v <= win_v;
      if (win_v) begin
        g_addr <= opix;
        g_data <= res;
      end
    end
  assign src_v = g_v;
  assign src_addr = g_addr;
  assign src_data = g_data;
`else
  logic unused_win;
  assign unused_win = ^top;
  assign src_v = win_v;
  assign src_addr = opix;
  assign src_data = lb1[1];
`endif
endmodule

// File: tb/tb_stream_filter_engine.sv
// tb_stream_filter_engine: scoreboard bench on an 8x8 frame served by a registered image memory.
module tb_stream_filter_engine;
  localparam int W = 8, H = 8, AW = 6, DW = 8, N = W * H;
`ifdef GAUSS3_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif
  localparam int T_FIN = N + W + 4 + LAT;
  typedef struct {int addr; int data;} exp_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [AW-1:0] in_addr, out_addr;
  logic [DW-1:0] in_data, out_data;
  logic [DW-1:0] mem [N];
  logic out_valid, finish;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, errors = 0;

  stream_filter_engine #(.WIDTH(W), .HEIGHT(H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .finish(finish));

  always #5 clk = ~clk;
  always @(posedge clk) in_data <= mem[in_addr];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model(int p);
`ifdef GAUSS3_EN
    int r = p / W, c = p % W, s = 0;
    if (r > 0 && r < H - 1 && c > 0 && c < W - 1) begin
      for (int dr = -1; dr <= 1; dr++)
        for (int dc = -1; dc <= 1; dc++)
          s += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * int'(mem[(r + dr) * W + c + dc]);
      return (s + 8) >> 4;
    end
`endif
    return int'(mem[p]);
  endfunction

  task automatic load(input int kind);
    for (int a = 0; a < N; a++)
      mem[a] = kind == 0 ? DW'((a * 37 + 5) % 256) : kind == 1 ? 8'd200 : (a == 4 * W + 4 ? 8'd255 : 8'd0);
    for (int p = 0; p < N; p++) sb.push_back('{p, model(p)});
  endtask

  always @(negedge clk)
    if (rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: addr %0d data %0d, expected no output", out_addr, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_addr", int'(out_addr), mon_e.addr);
        chk("out_data", int'(out_data), mon_e.data);
      end
    end

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_finish", finish, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_frame(input int stall_at, input int stall_len);
    int n = 0;
    bit stalled = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("start_addr", in_addr, 0);
    while (!finish && n < T_FIN + stall_len + 20) begin
      if (!stalled && stall_len > 0 && int'(in_addr) == stall_at) begin
        stalled = 1'b1;
        in_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk);
          n++;
          #1;
          chk("stall_hold", in_addr, stall_at);
        end
        in_valid = 1'b1;
      end
      @(posedge clk);
      n++;
      #1;
      if (n == 1) chk("first_step", in_addr, 1);
    end
    chk("finish_time", n, T_FIN + stall_len);
    chk("finish_valid", out_valid, 0);
    chk("all_outputs", sb.size(), 0);
    chk("drain_addr", in_addr, N - 1);
  endtask

  task automatic after_done();
    logic [AW-1:0] a = in_addr;
    for (int i = 0; i < 100; i++) begin
      in_valid = i[0];
      @(posedge clk);
      #1;
      chk("done_valid", out_valid, 0);
      chk("done_addr", in_addr, a);
      chk("done_finish", finish, 1);
    end
  endtask

  initial begin
    int n = 0;
    #3 do_reset();
    load(0);
    run_frame(0, 0);
    after_done();
    do_reset();
    load(1);
    run_frame(20, 10);
    do_reset();
    load(2);
    @(negedge clk);
    in_valid = 1'b1;
    while (int'(in_addr) != 30 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("abort_addr", in_addr, 30);
    do_reset();
    load(2);
    run_frame(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_filter_engine.md
Name: stream_filter_engine

Overview:
- Requester/DUT side of the image-memory protocol: issues raster read addresses (in_addr), consumes returned pixels (in_data), writes filtered pixels back by address (out_addr/out_data/out_valid) and raises finish when done.
- Holds two line buffers and a 3x3 window; the default build is a pixel pass-through with exact address alignment, used as the baseline datapath ahead of the full bilateral kernel.

Parameters:
- WIDTH, 256, pixels per row (power of two)
- HEIGHT, 256, rows per frame
- AW, 16, address width; WIDTH*HEIGHT = 2^AW
- DW, 8, pixel width

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  reset; asynchronous, active-low (0 = reset)
- in_valid  input  1  memory side ready; high enables address issue
- in_addr  output  AW  read address; the memory returns mem[in_addr] on in_data one cycle later
- in_data  input  DW  pixel for the in_addr issued on the previous cycle
- out_valid  output  1  out_addr/out_data valid this cycle
- out_addr  output  AW  raster address of the output pixel
- out_data  output  DW  output pixel
- finish  output  1  frame complete; held high until reset

Behaviour:
- Reset (rst=0, async): state IDLE, in_addr=0, out_valid=0, out_addr=0, out_data=0, finish=0; line buffers and window cleared; read counter cleared.
- FSM: IDLE -> READ on the first edge with in_valid=1. READ -> DRAIN after address WIDTH*HEIGHT-1 is issued. DRAIN -> DONE after the last output. DONE is absorbing until reset.
- READ: in_addr increments by 1 per edge while in_valid=1 (0,1,...,65535). When in_valid=0, in_addr holds and no new address is issued. Data for an already-issued address is still captured on the next edge.
- Capture: a pixel is accepted one edge after its address is issued, pushed into line buffer 0. Line buffer 0 shifts into line buffer 1 and the window at row/column granularity.
- Output for pixel p (row r, col c) is produced once pixel p+WIDTH+1 has been captured. out_valid=1 and out_addr=p on the edge after that capture, which is 2 cycles after in_addr=p+WIDTH+1 was issued.
- Exactly one out_valid per address 0..WIDTH*HEIGHT-1, in ascending order, with no duplicates.
- DRAIN: the pixels beyond the frame (WIDTH+1 virtual pixels) are generated internally at one per cycle, independent of in_valid. No reads are issued and in_addr holds at 65535.
- Border pixels (r=0, r=HEIGHT-1, c=0, c=WIDTH-1): out_data = centre pixel, unfiltered. Out-of-frame neighbours never contribute, including across row wrap.
- Interior pixels: kernel per Optional Feature.
- DONE: finish=1 on the edge after the final out_valid. From then on out_valid=0; both hold.
- Timing with no stalls: the first in_addr change is 1 cycle after IDLE exit. Total time from IDLE exit to finish = 65536 + 257 + 3 cycles.
- Reset mid-operation aborts immediately to the reset state. No further outputs are produced.
- in_valid toggling after DONE has no effect.

Optional Feature:
- Macro GAUSS3_EN.
- Defined: interior out_data = (sum + 8) >> 4, where sum = 4*centre + 2*(N+S+E+W) + (NE+NW+SE+SW).
  - sum is 12 bits; the maximum value 4080 rounds to 255, so no saturation is needed.
  - Adds one pipeline stage: out_valid comes 3 cycles after issue of p+WIDTH+1, and the total time becomes +1 cycle.
- Undefined: interior out_data = centre pixel (exact pass-through); no multiplier/adder tree is instantiated.

Test Plan:
- Ramp image mem[a]=a%256, in_valid held high, feature off -> out_data at every address 0..65535 equals mem[a]; each address written exactly once; finish high after 65796 cycles; out_valid=0 on the cycle finish is sampled.
- Constant image 200, GAUSS3_EN defined -> every output 200, including borders.
- Single bright pixel 255 at (128,128), all else 0, GAUSS3_EN -> (128,128)=64, orthogonal neighbours 32, diagonals 16, everything else 0; (0,5) stays equal to the input.
- in_valid low for 10 cycles at address 1000 -> in_addr holds at 1000 during the stall; output sequence is unchanged; finish is delayed by exactly 10 cycles.
- rst pulled low at address 30000 -> outputs clear immediately. After release plus in_valid, a full frame re-runs from address 0 with correct results.
- After finish: in_valid toggled for 100 cycles -> no out_valid, in_addr constant, finish stays 1.
